// File: rtl/bin2bcd_scan_if.sv
// Handshake/display bus between the CPU debug path and the BCD scan driver.
interface bin2bcd_scan_if #(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned BIN_W  = 27
);
  logic [BIN_W-1:0]  bin_in;
  logic              start;
  logic              lzb;
  logic              busy;
  logic              done;
  logic              ovf;
  logic [3:0]        bcd;
  logic [DIGITS-1:0] an;

  modport master (
    output bin_in, start, lzb,
    input  busy, done, ovf, bcd, an
  );

  modport slave (
    input  bin_in, start, lzb,
    output busy, done, ovf, bcd, an
  );
endinterface

// File: rtl/bin2bcd_scan.sv
// Sequential double-dabble binary-to-BCD converter feeding a time-multiplexed
// digit scan with active-low one-hot anodes and optional leading-zero blanking.
module bin2bcd_scan #(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned BIN_W       = 27,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_scan_if.slave bus
);

  localparam int unsigned DW    = 4 * DIGITS;
  localparam int unsigned IterW = $clog2(BIN_W + 1);
  localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CntW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  function automatic logic [63:0] max_val(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MaxVal = max_val(DIGITS);

  typedef enum logic [0:0] {StIdle, StConv} state_e;

  state_e           state_q, state_d;
  logic [BIN_W-1:0] shift_q, shift_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [IterW-1:0] iter_q, iter_d;
  logic             pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [DW-1:0]    disp_q, disp_d;
  logic [DW-1:0]    acc_adj;
  logic [DW-1:0]    acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      acc_q   <= '0;
      iter_q  <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      disp_q  <= '1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      iter_q  <= iter_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      disp_q  <= disp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    iter_d  = iter_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    disp_d  = disp_q;
    acc_adj = acc_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_next = {acc_adj[DW-2:0], shift_q[BIN_W-1]};

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          shift_d = bus.bin_in;
          acc_d   = '0;
          iter_d  = '0;
          pend_d  = 64'(bus.bin_in) > MaxVal;
          state_d = StConv;
        end
      end
      StConv: begin
        acc_d   = acc_next;
        shift_d = shift_q << 1;
        iter_d  = iter_q + IterW'(1);
        // A bit carried out of the top digit can only mean overflow.
        pend_d  = pend_q | acc_adj[DW-1];
        if (iter_q == IterW'(BIN_W - 1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
          ovf_d   = pend_d;
          disp_d  = pend_d ? '1 : acc_next;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Scan path: blanking is applied live so LZB takes effect on the next slot.
  logic [DW-1:0]     shown;
  logic              seen_nz;
  logic [CntW-1:0]   cnt_q;
  logic [IdxW-1:0]   idx_q;
  logic [3:0]        bcd_q;
  logic [DIGITS-1:0] an_q;

  always_comb begin
    shown   = disp_q;
    seen_nz = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      if (disp_q[4*i +: 4] != 4'd0) seen_nz = 1'b1;
      if (bus.lzb && !seen_nz && i != 0) shown[4*i +: 4] = 4'hF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      bcd_q <= 4'hF;
      an_q  <= '1;
    end else if (cnt_q == CntW'(REFRESH_DIV - 1)) begin
      cnt_q <= '0;
      idx_q <= (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
      bcd_q <= shown[{idx_q, 2'b00} +: 4];
      an_q  <= ~(DIGITS'(1) << idx_q);
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign bus.busy = (state_q == StConv);
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.bcd  = bcd_q;
  assign bus.an   = an_q;

endmodule

// File: tb/tb_bin2bcd_scan.sv
// Scenario bench for bin2bcd_scan: conversion timing, scan sequence, blanking, overflow, reset abort.
module tb_bin2bcd_scan;
  localparam int unsigned DIGITS      = 8;
  localparam int unsigned BIN_W       = 27;
  localparam int unsigned REFRESH_DIV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bin2bcd_scan_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bin2bcd_scan #(
    .DIGITS(DIGITS), .BIN_W(BIN_W), .REFRESH_DIV(REFRESH_DIV)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    bit              ovf;
    longint unsigned value;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [31:0] exp_frame(input longint unsigned v, input logic lz);
    logic [31:0]     f;
    longint unsigned r;
    int              msd;
    if (v > 64'd99999999) return '1;
    r   = v;
    msd = 0;
    for (int i = 0; i < 8; i++) begin
      f[4*i +: 4] = 4'(r % 10);
      r = r / 10;
      if (f[4*i +: 4] != 4'd0) msd = i;
    end
    if (lz) for (int i = 1; i < 8; i++) if (i > msd) f[4*i +: 4] = 4'hF;
    return f;
  endfunction

  // Let any pre-update slot drain, then record the latest code seen per anode.
  task automatic capture_frame(output logic [31:0] f, output logic [7:0] seen);
    f    = '1;
    seen = '0;
    repeat (5) @(negedge clk);
    repeat (40) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        if (bus.an == ~(8'd1 << i)) begin
          f[4*i +: 4] = bus.bcd;
          seen[i]     = 1'b1;
        end
      end
    end
  endtask

  task automatic start_conv(input longint unsigned v);
    @(negedge clk);
    bus.bin_in = BIN_W'(v);
    bus.start  = 1'b1;
    sb.push_back('{ovf: (v > 64'd99999999), value: v});
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bin_in = 27'h5A5A5A5;
  endtask

  task automatic finish_conv(input bit inject, input bit chain, input longint unsigned chain_v);
    int   busy_cnt = 0;
    int   dones    = 0;
    exp_t e;
    while (bus.busy && busy_cnt < 100) begin
      busy_cnt++;
      if (bus.done) dones++;
      if (inject && (busy_cnt == 5 || busy_cnt == 10)) begin
        bus.start  = 1'b1;
        bus.bin_in = 27'd777;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (busy_cnt != 27) begin
      n_err++;
      $display("FAIL busy_len: got %0d cycles, want 27", busy_cnt);
    end
    n_cmp++;
    if (dones != 0) begin
      n_err++;
      $display("FAIL done_early: got %0d pulses during busy, want 0", dones);
    end
    n_cmp++;
    if (bus.done !== 1'b1) begin
      n_err++;
      $display("FAIL done_pulse: got %b, want 1", bus.done);
    end
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL sb_empty: got 0 entries, want 1");
    end else begin
      e = sb.pop_front();
      if (bus.ovf !== e.ovf) begin
        n_err++;
        $display("FAIL ovf(%0d): got %b, want %b", e.value, bus.ovf, e.ovf);
      end
    end
    if (chain) begin
      bus.bin_in = BIN_W'(chain_v);
      bus.start  = 1'b1;
      sb.push_back('{ovf: (chain_v > 64'd99999999), value: chain_v});
    end
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL done_single: got %b, want 0", bus.done);
    end
    if (chain) begin
      n_cmp++;
      if (bus.busy !== 1'b1) begin
        n_err++;
        $display("FAIL chain_busy: got %b, want 1", bus.busy);
      end
    end
  endtask

  task automatic check_frame(input string name, input longint unsigned v, input logic lz);
    logic [31:0] f;
    logic [7:0]  seen;
    bus.lzb = lz;
    capture_frame(f, seen);
    n_cmp++;
    if (f !== exp_frame(v, lz) || seen !== 8'hFF) begin
      n_err++;
      $display("FAIL %s: got digits %h seen %h, want digits %h seen ff",
               name, f, seen, exp_frame(v, lz));
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.an !== 8'hFF || bus.bcd !== 4'hF || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got an=%h bcd=%h busy=%b done=%b ovf=%b, want ff f 0 0 0",
               bus.an, bus.bcd, bus.busy, bus.done, bus.ovf);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (bus.an !== 8'hFF || bus.bcd !== 4'hF) begin
        n_err++;
        $display("FAIL idle_pre_scan: got an=%h bcd=%h, want ff f", bus.an, bus.bcd);
      end
    end
    for (int s = 0; s < 9; s++) begin
      repeat (REFRESH_DIV) begin
        @(negedge clk);
        n_cmp++;
        if (bus.an !== ~(8'd1 << (s % 8)) || bus.bcd !== 4'hF) begin
          n_err++;
          $display("FAIL idle_scan slot %0d: got an=%h bcd=%h, want an=%h bcd=f",
                   s, bus.an, bus.bcd, ~(8'd1 << (s % 8)));
        end
      end
    end
  endtask

  task automatic test_convert;
    start_conv(64'd12345678);
    finish_conv(1'b0, 1'b0, 64'd0);
    check_frame("frame_12345678", 64'd12345678, 1'b0);
  endtask

  task automatic test_lzb;
    start_conv(64'd305);
    finish_conv(1'b0, 1'b0, 64'd0);
    check_frame("frame_305_lzb1", 64'd305, 1'b1);
    check_frame("frame_305_lzb0", 64'd305, 1'b0);
    start_conv(64'd0);
    finish_conv(1'b0, 1'b0, 64'd0);
    check_frame("frame_0_lzb1", 64'd0, 1'b1);
    bus.lzb = 1'b0;
  endtask

  task automatic test_overflow;
    start_conv(64'd100000000);
    finish_conv(1'b0, 1'b0, 64'd0);
    check_frame("frame_ovf", 64'd100000000, 1'b0);
    start_conv(64'd42);
    finish_conv(1'b0, 1'b0, 64'd0);
    check_frame("frame_42_after_ovf", 64'd42, 1'b0);
  endtask

  task automatic test_start_ignored;
    start_conv(64'd24681357);
    finish_conv(1'b1, 1'b0, 64'd0);
    check_frame("frame_start_ignored", 64'd24681357, 1'b0);
  endtask

  task automatic test_back_to_back;
    start_conv(64'd11);
    finish_conv(1'b0, 1'b1, 64'd87654321);
    finish_conv(1'b0, 1'b0, 64'd0);
    check_frame("frame_back_to_back", 64'd87654321, 1'b0);
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    start_conv(64'd99999999);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.an !== 8'hFF || bus.bcd !== 4'hF || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: got an=%h bcd=%h busy=%b done=%b, want ff f 0 0",
               bus.an, bus.bcd, bus.busy, bus.done);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    n_cmp++;
    if (dones != 0) begin
      n_err++;
      $display("FAIL reset_no_done: got %0d pulses, want 0", dones);
    end
    check_frame("frame_after_abort", 64'd100000000, 1'b0);
  endtask

  initial begin
    bus.bin_in = '0;
    bus.start  = 1'b0;
    bus.lzb    = 1'b0;
    test_reset();
    test_convert();
    test_lzb();
    test_overflow();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bin2bcd_scan.md
Name: bin2bcd_scan

Overview:
- Upstream feeder for the BCD-to-seven-segment decoder on the board display path.
- Accepts a binary value from the CPU debug path (PC, register or ALU result) on a start strobe.
- Converts it to packed BCD with a sequential shift-add-3 (double-dabble) engine and holds the result in a display register.
- Time-multiplexes the digits onto one 4-bit BCD bus with an active-low anode select. The BCD bus drives the decoder; the anode bus drives the board.

Parameters:
- DIGITS, 8: number of display digits / anodes.
- BIN_W, 27: binary input width. Must satisfy 2^BIN_W > 10^DIGITS - 1.
- REFRESH_DIV, 100000: CLK cycles each digit stays selected (1 kHz per digit at 100 MHz).

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous active-high reset
- BIN_IN  in  BIN_W  binary value to convert
- START  in  1  single-cycle request; sampled only in IDLE
- LZB  in  1  leading-zero blanking enable, applied combinationally to the display register at scan time
- BUSY  out  1  conversion in progress
- DONE  out  1  one-cycle pulse when the display register updates
- OVF  out  1  last captured value exceeded 10^DIGITS - 1
- BCD  out  4  digit code to the decoder; 4'hF means blank
- AN  out  DIGITS  anode select, active-low one-hot

Behaviour:
- Reset (async, RST=1):
  - State IDLE; BUSY=0, DONE=0, OVF=0.
  - Display register all 4'hF, so the display is blank.
  - BCD=4'hF, AN all ones, digit index 0, refresh counter 0.
- FSM states: IDLE, CONV.
  - IDLE: on START=1 at edge k, capture BIN_IN into the shift register, clear the BCD accumulator and iteration counter, go to CONV, BUSY=1.
  - CONV: on each edge, for every BCD nibble, add 3 if it is >=5. Then shift {accumulator, shift reg} left one bit. Increment the iteration counter.
  - The BIN_W-th iteration occurs at edge k+BIN_W. At that edge: state goes to IDLE, BUSY=0, DONE=1 for exactly one cycle, and the display register and OVF update.
  - BUSY is high for exactly BIN_W cycles. START during CONV is ignored and not queued.
  - START in the cycle DONE is high is accepted, because the state is already IDLE.
- Overflow:
  - Compare at capture: BIN_IN > 10^DIGITS - 1 sets a pending flag.
  - At completion: OVF takes the pending flag. If set, the display register is loaded with all 4'hF instead of the converted digits.
  - OVF holds until the next completion or reset.
- Leading-zero blanking (LZB=1):
  - Every digit above the most significant nonzero digit is presented as 4'hF.
  - Digit 0 is always shown, so value 0 displays "0".
  - No effect when OVF is set (already blank).
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - At terminal count the counter returns to 0 and the digit index increments, wrapping DIGITS-1 to 0.
  - On that same edge, BCD and AN are registered together: AN[index]=0, all other AN bits 1, BCD = post-blanking digit[index].
  - The display register swaps atomically at DONE, so there is never a mixed old/new frame within a digit slot.
- Reset mid-conversion: abort; the display register returns to blank; no DONE is issued.
- BIN_IN is only sampled at the START edge; later changes have no effect.

Test Plan:
- Reset then idle (REFRESH_DIV=4, DIGITS=8):
  - AN=8'hFF and BCD=4'hF until the first terminal count.
  - Then AN steps FE, FD, FB ... 7F, FE, each held for 4 cycles, with BCD=F throughout.
- BIN_IN=12345678, START pulse:
  - BUSY high for exactly 27 cycles, then DONE pulses once.
  - Scan shows BCD 8,7,6,5,4,3,2,1 on AN FE..7F; OVF=0.
- BIN_IN=305, LZB=1:
  - Digits 0..2 show 5,0,3; digits 3..7 show F.
  - With LZB=0, digits 3..7 show 0.
  - BIN_IN=0 with LZB=1: digit 0 shows 0, all others F.
- BIN_IN=100000000 (>99999999): after 27 cycles OVF=1 and all digits show F. A following conversion of 42 clears OVF.
- START pulses at cycles 5 and 10 of a conversion: ignored; single DONE; result matches the first value. START coincident with DONE starts a new conversion.
- RST asserted at iteration 13 of a conversion of 99999999:
  - Immediately AN=FF, BCD=F, BUSY=0; no DONE.
  - After release the display stays blank until a new START.
